washer_cycle_ctrl: RTL and testbench
====================================

Name: washer_cycle_ctrl

Overview:
- Sequencer for the washing-machine datapath. Steps through FILL, WASH, DRAIN, RINSE and SPIN, times each phase with a shared prescaler and phase timer, and drives the actuator enables.
- Sits between the front-panel inputs (start/abort/door) and the valve, motor, drain and lock drivers.
- Supports hold (pause or door open) and abort-to-drain.

Parameters:
- TICK_DIV, 4: clock cycles per timer tick (>=1).
- FILL_TICKS, 5: ticks spent in FILL (>=1).
- WASH_TICKS, 8: ticks spent in WASH (>=1).
- DRAIN_TICKS, 3: ticks spent in DRAIN (>=1).
- RINSE_TICKS, 5: ticks spent in RINSE (>=1).
- SPIN_TICKS, 6: ticks spent in SPIN (>=1).

Ports:
- clk, input, 1: system clock, rising edge.
- rstn, input, 1: asynchronous active-low reset.
- start, input, 1: level; begins a cycle when sampled in IDLE with door_closed=1.
- abort, input, 1: level; cancels an active cycle.
- pause, input, 1: level; holds the timers while high.
- door_closed, input, 1: door sensor, 1 = closed.
- valve_open, output, 1: water inlet enable.
- motor_on, output, 1: drum motor enable.
- motor_fast, output, 1: high-speed spin select.
- drain_on, output, 1: drain pump enable.
- door_lock, output, 1: door latch.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse on normal completion.
- state, output, 3: current state encoding.

Behaviour:
- Clock and reset:
  - One clock: clk. Reset is asynchronous and active-low on rstn.
  - In reset: state=IDLE, prescaler=0, phase timer=0, aborting=0, rinse_pass=0, all outputs 0.
- State encoding: IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6. Value 7 is illegal and recovers to IDLE on the next edge.
- Output decode (Moore, decoded from the state register only):
  - FILL: valve_open.
  - WASH: motor_on.
  - DRAIN: drain_on.
  - RINSE: valve_open and motor_on.
  - SPIN: motor_on, motor_fast and drain_on.
  - door_lock = busy = (state != IDLE). done = (state == DONE).
- Start:
  - IDLE with start=1 and door_closed=1: next edge goes to FILL; prescaler and timer cleared.
  - start with door_closed=0: ignored.
  - start in any non-IDLE state: ignored.
- hold = pause | ~door_closed. Evaluated only in FILL..SPIN. While hold=1, prescaler and timer freeze and the state does not change. Outputs stay as decoded; no actuator gating.
- Timing:
  - Prescaler counts 0..TICK_DIV-1 while running and not held.
  - tick = (prescaler == TICK_DIV-1) & ~hold.
  - Phase timer increments on tick.
  - Phase end = tick & (timer == PHASE_TICKS-1). On phase end: advance state, clear prescaler and timer.
  - Each phase therefore occupies exactly PHASE_TICKS*TICK_DIV unheld cycles.
- Transitions on phase end: FILL->WASH, WASH->DRAIN, DRAIN->RINSE, RINSE->SPIN, SPIN->DONE.
- DONE lasts exactly 1 cycle, then IDLE.
- Abort:
  - abort=1 in FILL, WASH, RINSE or SPIN: next edge goes to DRAIN, sets aborting=1, clears the timers. Abort overrides hold and a same-cycle phase end.
  - DRAIN end with aborting=1: go to IDLE (no DONE, no done pulse), clear aborting.
  - abort during DRAIN: restarts nothing and extends nothing.
  - abort in IDLE or DONE: ignored.
- Widths: timer width = $clog2(max phase ticks + 1); prescaler width = $clog2(TICK_DIV + 1). No wrap is possible, since both clear at their terminal values.
- Reset asserted mid-cycle: immediate return to reset values; all actuators off asynchronously.

Optional Feature:
- Macro: WASHER_DOUBLE_RINSE_EN.
- Defined:
  - On the first RINSE end with rinse_pass=0: go to DRAIN, set rinse_pass=1.
  - Non-abort DRAIN end with rinse_pass=1: go to RINSE.
  - Second RINSE end: go to SPIN.
  - rinse_pass clears in IDLE and on abort.
  - Adds DRAIN_TICKS+RINSE_TICKS ticks to a cycle.
- Undefined: single rinse; rinse_pass logic absent.

Test Plan (TICK_DIV=2, FILL=2, WASH=3, DRAIN=1, RINSE=2, SPIN=2 unless noted):
- Nominal cycle: start pulse, door closed -> FILL entered the edge after start. State sequence 1,2,3,4,5 with dwell 4,6,2,4,4 cycles. done high exactly 1 cycle, 20 cycles after FILL entry. Then state=0, busy=0.
- Door interlock: start with door_closed=0 -> stays IDLE, busy=0. Then open the door for 5 cycles during WASH -> state frozen; total cycle lengthens to 25 cycles; outputs unchanged during the hold.
- Pause on a tick boundary: pause=1 on the cycle where prescaler=1 and timer=WASH_TICKS-1 -> no transition. Releasing pause -> WASH ends on the next tick.
- Abort: abort in WASH -> next state DRAIN (drain_on=1), 2 cycles later IDLE, done never asserted. Abort with the same-cycle phase end in FILL -> DRAIN, not WASH.
- Reset mid-SPIN: rstn low -> motor_on, motor_fast, drain_on and door_lock go to 0 before the next clk edge. After release: IDLE.
- With WASHER_DOUBLE_RINSE_EN: sequence 1,2,3,4,3,4,5,6, and done at 26 cycles after FILL entry.

Source files
------------

// File: rtl/washer_cycle_ctrl.sv
// Washing-machine cycle sequencer: FILL/WASH/DRAIN/RINSE/SPIN with a shared prescaler and phase timer.
// Optional second rinse pass is enabled by defining WASHER_DOUBLE_RINSE_EN.
module washer_cycle_ctrl #(
   parameter int unsigned TICK_DIV    = 4,
   parameter int unsigned FILL_TICKS  = 5,
   parameter int unsigned WASH_TICKS  = 8,
   parameter int unsigned DRAIN_TICKS = 3,
   parameter int unsigned RINSE_TICKS = 5,
   parameter int unsigned SPIN_TICKS  = 6
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   input  logic       abort,
   input  logic       pause,
   input  logic       door_closed,
   output logic       valve_open,
   output logic       motor_on,
   output logic       motor_fast,
   output logic       drain_on,
   output logic       door_lock,
   output logic       busy,
   output logic       done,
   output logic [2:0] state
);

   localparam int unsigned MAX_A     = (FILL_TICKS > WASH_TICKS) ? FILL_TICKS : WASH_TICKS;
   localparam int unsigned MAX_B     = (DRAIN_TICKS > RINSE_TICKS) ? DRAIN_TICKS : RINSE_TICKS;
   localparam int unsigned MAX_C     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned MAX_TICKS = (MAX_C > SPIN_TICKS) ? MAX_C : SPIN_TICKS;
   localparam int unsigned TW        = $clog2(MAX_TICKS + 1);
   localparam int unsigned PW        = $clog2(TICK_DIV + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_WASH  = 3'd2,
      S_DRAIN = 3'd3,
      S_RINSE = 3'd4,
      S_SPIN  = 3'd5,
      S_DONE  = 3'd6
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [TW-1:0] last_tmr;
   logic          aborting_q, aborting_d;
   logic          hold;
   logic          valve_d, motor_d, fast_d, drain_d, busy_d, done_d;
`ifdef WASHER_DOUBLE_RINSE_EN
   logic          rinse_pass_q, rinse_pass_d;
`endif

   assign hold  = pause | ~door_closed;
   assign state = state_q;

   // Terminal timer value of the phase currently running
   always_comb begin
      last_tmr = '0;
      case (state_q)
         S_FILL:  last_tmr = TW'(FILL_TICKS - 1);
         S_WASH:  last_tmr = TW'(WASH_TICKS - 1);
         S_DRAIN: last_tmr = TW'(DRAIN_TICKS - 1);
         S_RINSE: last_tmr = TW'(RINSE_TICKS - 1);
         S_SPIN:  last_tmr = TW'(SPIN_TICKS - 1);
         default: last_tmr = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         pre_q        <= '0;
         tmr_q        <= '0;
         aborting_q   <= 1'b0;
`ifdef WASHER_DOUBLE_RINSE_EN
         rinse_pass_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pre_q        <= pre_d;
         tmr_q        <= tmr_d;
         aborting_q   <= aborting_d;
`ifdef WASHER_DOUBLE_RINSE_EN
         rinse_pass_q <= rinse_pass_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      pre_d        = pre_q;
      tmr_d        = tmr_q;
      aborting_d   = aborting_q;
`ifdef WASHER_DOUBLE_RINSE_EN
      rinse_pass_d = rinse_pass_q;
`endif
      case (state_q)
         S_IDLE: begin
            aborting_d = 1'b0;
`ifdef WASHER_DOUBLE_RINSE_EN
            rinse_pass_d = 1'b0;
`endif
            if (start && door_closed) begin
               state_d = S_FILL;
               pre_d   = '0;
               tmr_d   = '0;
            end
         end
         S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN: begin
            // Abort wins over hold and over a same-cycle phase end
            if (abort && (state_q != S_DRAIN)) begin
               state_d    = S_DRAIN;
               aborting_d = 1'b1;
               pre_d      = '0;
               tmr_d      = '0;
`ifdef WASHER_DOUBLE_RINSE_EN
               rinse_pass_d = 1'b0;
`endif
            end else if (!hold) begin
               if (pre_q == PW'(TICK_DIV - 1)) begin
                  pre_d = '0;
                  if (tmr_q == last_tmr) begin
                     tmr_d = '0;
                     case (state_q)
                        S_FILL: state_d = S_WASH;
                        S_WASH: state_d = S_DRAIN;
                        S_DRAIN: begin
                           if (aborting_q) begin
                              state_d    = S_IDLE;
                              aborting_d = 1'b0;
                           end else begin
                              state_d = S_RINSE;
                           end
                        end
`ifdef WASHER_DOUBLE_RINSE_EN
                        S_RINSE: begin
                           if (!rinse_pass_q) begin
                              state_d      = S_DRAIN;
                              rinse_pass_d = 1'b1;
                           end else begin
                              state_d = S_SPIN;
                           end
                        end
`else
                        S_RINSE: state_d = S_SPIN;
`endif
                        default: state_d = S_DONE;
                     endcase
                  end else begin
                     tmr_d = tmr_q + TW'(1);
                  end
               end else begin
                  pre_d = pre_q + PW'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Actuator decode of the next state, registered alongside the state itself
   always_comb begin
      valve_d = (state_d == S_FILL) || (state_d == S_RINSE);
      motor_d = (state_d == S_WASH) || (state_d == S_RINSE) || (state_d == S_SPIN);
      fast_d  = (state_d == S_SPIN);
      drain_d = (state_d == S_DRAIN) || (state_d == S_SPIN);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valve_open <= 1'b0;
         motor_on   <= 1'b0;
         motor_fast <= 1'b0;
         drain_on   <= 1'b0;
         door_lock  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         valve_open <= valve_d;
         motor_on   <= motor_d;
         motor_fast <= fast_d;
         drain_on   <= drain_d;
         door_lock  <= busy_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

endmodule

// File: tb/tb_washer_cycle_ctrl.sv
// Scoreboard bench for washer_cycle_ctrl: phase-budget reference model plus directed timing checks.
module tb_washer_cycle_ctrl;

   localparam int TD = 2;
   localparam int FT = 2;
   localparam int WT = 3;
   localparam int DT = 1;
   localparam int RT = 2;
   localparam int ST = 2;
`ifdef WASHER_DOUBLE_RINSE_EN
   localparam int NOM_LEN = 26;
`else
   localparam int NOM_LEN = 20;
`endif

   logic       clk = 1'b0;
   logic       rstn, start, abort, pause, door_closed;
   logic       valve_open, motor_on, motor_fast, drain_on, door_lock, busy, done;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   logic [9:0] exp_q[$];

   // Reference model: current phase and remaining unheld cycles in it
   int m_state = 0;
   int m_rem   = 0;
   bit m_abort = 0;
   bit m_rpass = 0;

   always #5 clk = ~clk;

   washer_cycle_ctrl #(
      .TICK_DIV(TD), .FILL_TICKS(FT), .WASH_TICKS(WT),
      .DRAIN_TICKS(DT), .RINSE_TICKS(RT), .SPIN_TICKS(ST)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .pause(pause),
      .door_closed(door_closed), .valve_open(valve_open), .motor_on(motor_on),
      .motor_fast(motor_fast), .drain_on(drain_on), .door_lock(door_lock),
      .busy(busy), .done(done), .state(state)
   );

   function automatic int phase_cycles(input int s);
      case (s)
         1: return FT * TD;
         2: return WT * TD;
         3: return DT * TD;
         4: return RT * TD;
         5: return ST * TD;
         default: return 0;
      endcase
   endfunction

   function automatic logic [9:0] decode(input int s);
      logic [2:0] st;
      st = 3'(s);
      return {st, (s == 1 || s == 4), (s == 2 || s == 4 || s == 5), (s == 5),
              (s == 3 || s == 5), (s != 0), (s != 0), (s == 6)};
   endfunction

   task automatic enter(input int s);
      m_state = s;
      m_rem   = phase_cycles(s);
   endtask

   task automatic model_step(input bit st, input bit ab, input bit pa, input bit dc);
      bit hold;
      hold = pa || !dc;
      case (m_state)
         0: begin
            m_abort = 0;
            m_rpass = 0;
            if (st && dc) enter(1);
         end
         1, 2, 3, 4, 5: begin
            if (ab && m_state != 3) begin
               enter(3);
               m_abort = 1;
               m_rpass = 0;
            end else if (!hold) begin
               m_rem--;
               if (m_rem == 0) begin
                  case (m_state)
                     1: enter(2);
                     2: enter(3);
                     3: begin
                        if (m_abort) begin
                           m_abort = 0;
                           enter(0);
                        end else enter(4);
                     end
                     4: begin
`ifdef WASHER_DOUBLE_RINSE_EN
                        if (!m_rpass) begin
                           m_rpass = 1;
                           enter(3);
                        end else enter(5);
`else
                        enter(5);
`endif
                     end
                     default: enter(6);
                  endcase
               end
            end
         end
         default: enter(0);
      endcase
   endtask

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Drive one cycle's inputs and queue the state/outputs expected after the next edge
   task automatic drive(input bit st, input bit ab, input bit pa, input bit dc);
      @(negedge clk);
      start = st; abort = ab; pause = pa; door_closed = dc;
      model_step(st, ab, pa, dc);
      exp_q.push_back(decode(m_state));
   endtask

   task automatic drive_obs(input bit st, input bit ab, input bit pa, input bit dc);
      drive(st, ab, pa, dc);
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_done(input int maxc, output int n);
      n = -1;
      for (int i = 1; i <= maxc; i++) begin
         drive_obs(0, 0, 0, 1);
         if (done) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 1);
   endtask

   // Monitor: compare every observed cycle against the scoreboard
   always @(posedge clk) begin
      logic [9:0] e;
      logic [9:0] got;
      #1;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {state, valve_open, motor_on, motor_fast, drain_on, door_lock, busy, done};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL cycle_out at %0t: got state=%0d outs=%b expected state=%0d outs=%b",
                     $time, got[9:7], got[6:0], e[9:7], e[6:0]);
         end
      end
   end

   initial begin
      int n;
      rstn = 1'b0; start = 0; abort = 0; pause = 0; door_closed = 1;
      @(negedge clk);
      check("reset_outputs", int'({valve_open, motor_on, motor_fast, drain_on, door_lock, busy, done}), 0);
      check("reset_state", int'(state), 0);
      @(negedge clk);
      rstn = 1'b1;

      // Start with door open is ignored
      drive(1, 0, 0, 0);
      drive_obs(0, 0, 0, 1);
      check("door_open_start_busy", int'(busy), 0);

      // Nominal cycle length from FILL entry to done
      drive(1, 0, 0, 1);
      run_until_done(60, n);
      check("nominal_len", n, NOM_LEN);
      drive_obs(0, 0, 0, 1);
      check("after_done_state", int'(state), 0);
      check("after_done_busy", int'(busy), 0);

      // Door opened for 5 cycles during WASH lengthens the cycle by 5
      drive(1, 0, 0, 1);
      idle(6);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
      run_until_done(60, n);
      check("door_hold_len", 11 + n, NOM_LEN + 5);
      idle(2);

      // Pause on the final WASH tick blocks the transition until released
      drive(1, 0, 0, 1);
      idle(9);
      drive_obs(0, 0, 1, 1);
      check("pause_hold_state", int'(state), 2);
      drive_obs(0, 0, 0, 1);
      check("pause_release_state", int'(state), 3);
      run_until_done(60, n);
      check("pause_done_seen", int'(n > 0), 1);
      idle(2);

      // Abort in WASH drains then returns to IDLE without done
      drive(1, 0, 0, 1);
      idle(5);
      drive_obs(0, 1, 0, 1);
      check("abort_wash_state", int'(state), 3);
      check("abort_wash_drain", int'(drain_on), 1);
      drive(0, 0, 0, 1);
      drive_obs(0, 0, 0, 1);
      check("abort_return_idle", int'(state), 0);

      // Abort coinciding with the FILL phase end
      drive(1, 0, 0, 1);
      idle(3);
      drive_obs(0, 1, 0, 1);
      check("abort_fill_end_state", int'(state), 3);
      idle(4);

      // Reset mid-SPIN turns actuators off before the next edge
      drive(1, 0, 0, 1);
      n = 0;
      while (m_state != 5 && n < 80) begin
         drive(0, 0, 0, 1);
         n++;
      end
      check("reach_spin", int'(m_state == 5), 1);
      drive(0, 0, 0, 1);
      @(negedge clk);
      #1;
      rstn = 1'b0;
      #1;
      check("async_reset_outs", int'({motor_on, motor_fast, drain_on, door_lock}), 0);
      start = 0; abort = 0; pause = 0; door_closed = 1;
      m_state = 0; m_rem = 0; m_abort = 0; m_rpass = 0;
      exp_q.push_back(decode(0));
      @(negedge clk);
      rstn = 1'b1;
      drive_obs(0, 0, 0, 1);
      check("post_reset_state", int'(state), 0);

      // Randomized front-panel activity
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom % 6) == 0, ($urandom % 60) == 0,
               ($urandom % 10) == 0, ($urandom % 12) != 0);
      end
      idle(40);
      @(posedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
